// File: rtl/config_reg_arbiter.sv
// Round-robin arbiter that shares the single-port config_reg (8 x 16-bit) between N_REQ
// requesters. It grants one request at a time, drives the config_reg address/write/data
// ports, captures read data after RD_LATENCY cycles and returns a one-cycle ack pulse.
// Optional build macro CFG_WRITE_VERIFY_EN: every write is read back after RD_LATENCY cycles
// and a mismatch sets the sticky verify_err flag; without it verify_err is tied low.
module config_reg_arbiter #(
  parameter int unsigned N_REQ      = 2,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ-1:0]      req_we,
  input  logic [3*N_REQ-1:0]    req_addr,
  input  logic [16*N_REQ-1:0]   req_wdata,
  output logic [N_REQ-1:0]      ack,
  output logic [15:0]           rdata,
  output logic                  busy,
  output logic [2:0]            cfg_address,
  output logic                  cfg_write,
  output logic [15:0]           cfg_data_in,
  input  logic [15:0]           cfg_data_out,
  output logic                  verify_err
);

  localparam int unsigned IdxW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned IdxW1 = IdxW + 1;
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(N_REQ - 1);
  localparam logic [1:0]      WaitLast = 2'(RD_LATENCY - 1);

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StVerifyWait,
    StDone
  } state_e;

  state_e            state_q;
  logic [IdxW-1:0]   rr_q;
  logic [IdxW-1:0]   grant_q;
  logic [1:0]        wait_cnt_q;
  logic [N_REQ-1:0]  ack_q;
  logic [15:0]       rdata_q;
  logic              busy_q;
  logic [2:0]        cfg_address_q;
  logic              cfg_write_q;
  logic [15:0]       cfg_data_in_q;

  logic [2:0]        addr_arr  [N_REQ];
  logic [15:0]       wdata_arr [N_REQ];
  logic              pick_valid;
  logic [IdxW-1:0]   pick_idx;
  logic [IdxW:0]     scan_idx;
  logic [N_REQ-1:0]  grant_onehot;
  logic [IdxW-1:0]   rr_next;

  // Unpack the flat per-requester address and data buses.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      addr_arr[i]  = req_addr[3*i +: 3];
      wdata_arr[i] = req_wdata[16*i +: 16];
    end
  end

  // Pick the first active request at or above the rr pointer, wrapping at N_REQ-1.
  // Scanning downwards lets the closest candidate to the pointer win.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    scan_idx   = '0;
    for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
      scan_idx = {1'b0, rr_q} + IdxW1'(i);
      if (scan_idx >= IdxW1'(N_REQ)) begin
        scan_idx = scan_idx - IdxW1'(N_REQ);
      end
      if (req[scan_idx[IdxW-1:0]]) begin
        pick_valid = 1'b1;
        pick_idx   = scan_idx[IdxW-1:0];
      end
    end
  end

  assign grant_onehot = N_REQ'(1) << grant_q;
  assign rr_next      = (grant_q == LastIdx) ? '0 : grant_q + IdxW'(1);

`ifdef CFG_WRITE_VERIFY_EN
  logic verify_err_q;
`endif

  // Transfer sequencer; all outputs are registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      rr_q          <= '0;
      grant_q       <= '0;
      wait_cnt_q    <= '0;
      ack_q         <= '0;
      rdata_q       <= '0;
      busy_q        <= 1'b0;
      cfg_address_q <= '0;
      cfg_write_q   <= 1'b0;
      cfg_data_in_q <= '0;
`ifdef CFG_WRITE_VERIFY_EN
      verify_err_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (pick_valid) begin
            grant_q       <= pick_idx;
            cfg_address_q <= addr_arr[pick_idx];
            cfg_write_q   <= req_we[pick_idx];
            cfg_data_in_q <= wdata_arr[pick_idx];
            busy_q        <= 1'b1;
            state_q       <= StIssue;
          end
        end
        StIssue: begin
          // cfg_write_q still holds the latched direction of this transfer.
          cfg_write_q <= 1'b0;
          wait_cnt_q  <= '0;
          if (cfg_write_q) begin
`ifdef CFG_WRITE_VERIFY_EN
            state_q <= StVerifyWait;
`else
            ack_q   <= grant_onehot;
            state_q <= StDone;
`endif
          end else begin
            state_q <= StWait;
          end
        end
        StWait: begin
          if (wait_cnt_q == WaitLast) begin
            rdata_q <= cfg_data_out;
            ack_q   <= grant_onehot;
            state_q <= StDone;
          end else begin
            wait_cnt_q <= wait_cnt_q + 2'd1;
          end
        end
`ifdef CFG_WRITE_VERIFY_EN
        StVerifyWait: begin
          if (wait_cnt_q == WaitLast) begin
            if (cfg_data_out != cfg_data_in_q) begin
              verify_err_q <= 1'b1;
            end
            ack_q   <= grant_onehot;
            state_q <= StDone;
          end else begin
            wait_cnt_q <= wait_cnt_q + 2'd1;
          end
        end
`endif
        StDone: begin
          ack_q   <= '0;
          busy_q  <= 1'b0;
          rr_q    <= rr_next;
          state_q <= StIdle;
        end
        default: begin
          ack_q       <= '0;
          busy_q      <= 1'b0;
          cfg_write_q <= 1'b0;
          state_q     <= StIdle;
        end
      endcase
    end
  end

  assign ack         = ack_q;
  assign rdata       = rdata_q;
  assign busy        = busy_q;
  assign cfg_address = cfg_address_q;
  assign cfg_write   = cfg_write_q;
  assign cfg_data_in = cfg_data_in_q;
`ifdef CFG_WRITE_VERIFY_EN
  assign verify_err  = verify_err_q;
`else
  assign verify_err  = 1'b0;
`endif

endmodule

// File: tb/tb_config_reg_arbiter.sv
// Self-checking bench for config_reg_arbiter: a behavioural config_reg model supplies read
// data, and a reference model (memory image, last read value, round-robin pointer) predicts
// every ack, latency and read value. Honours CFG_WRITE_VERIFY_EN when defined.
module tb_config_reg_arbiter;

  localparam int N      = 2;
  localparam int RL     = 1;
  localparam int RD_LAT = 2 + RL;
`ifdef CFG_WRITE_VERIFY_EN
  localparam int WR_LAT = 2 + RL;
`else
  localparam int WR_LAT = 2;
`endif

  localparam logic [15:0] INIT_MEM [8] = '{16'hFFFF, 16'h0000, 16'h1234, 16'h0000,
                                           16'hABCD, 16'h5555, 16'h0000, 16'h0001};

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [N-1:0]     req = '0;
  logic [N-1:0]     req_we = '0;
  logic [3*N-1:0]   req_addr = '0;
  logic [16*N-1:0]  req_wdata = '0;
  logic [N-1:0]     ack;
  logic [15:0]      rdata;
  logic             busy;
  logic [2:0]       cfg_address;
  logic             cfg_write;
  logic [15:0]      cfg_data_in;
  logic [15:0]      cfg_data_out;
  logic             verify_err;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  logic [15:0] ref_mem [8] = INIT_MEM;
  logic [15:0] ref_rdata = '0;
  int          ref_rr = 0;

  // Behavioural config_reg: write-through registered read with RL stages.
  logic [15:0] env_mem [8] = INIT_MEM;
  logic [15:0] rd_pipe [RL] = '{default: '0};
  bit          force_bad = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (cfg_write) env_mem[cfg_address] <= cfg_data_in;
    if (cfg_write) rd_pipe[0] <= force_bad ? 16'h5EAB : cfg_data_in;
    else           rd_pipe[0] <= env_mem[cfg_address];
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign cfg_data_out = rd_pipe[RL-1];

  config_reg_arbiter #(
    .N_REQ      (N),
    .RD_LATENCY (RL)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .ack          (ack),
    .rdata        (rdata),
    .busy         (busy),
    .cfg_address  (cfg_address),
    .cfg_write    (cfg_write),
    .cfg_data_in  (cfg_data_in),
    .cfg_data_out (cfg_data_out),
    .verify_err   (verify_err)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    ref_rr = 0;
    ref_rdata = '0;
  endtask

  // Drive one isolated request from an idle arbiter and observe its completion.
  task automatic run_txn(input int r, input bit we, input logic [2:0] addr,
                         input logic [15:0] wd, output int lat, output logic [N-1:0] ack_seen,
                         output logic [15:0] rd_seen, output int wr_pulses,
                         output logic [N-1:0] ack_after, output logic busy_after);
    @(negedge clk);
    req[r] = 1'b1;
    req_we[r] = we;
    req_addr[3*r +: 3] = addr;
    req_wdata[16*r +: 16] = wd;
    lat = -1;
    wr_pulses = 0;
    ack_seen = '0;
    rd_seen = 'x;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (cfg_write) wr_pulses++;
      if (ack != '0) begin
        lat = c;
        ack_seen = ack;
        rd_seen = rdata;
        break;
      end
    end
    req[r] = 1'b0;
    @(negedge clk);
    ack_after = ack;
    busy_after = busy;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (ack !== '0) begin errors++; $display("FAIL reset_ack got %h want 0", ack); end
    checks++; if (rdata !== '0) begin errors++; $display("FAIL reset_rdata got %h want 0", rdata); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++;
    if (cfg_address !== '0) begin errors++; $display("FAIL reset_addr got %h want 0", cfg_address); end
    checks++;
    if (cfg_write !== 1'b0) begin errors++; $display("FAIL reset_write got %b want 0", cfg_write); end
    checks++;
    if (cfg_data_in !== '0) begin errors++; $display("FAIL reset_wdata got %h want 0", cfg_data_in); end
    checks++;
    if (verify_err !== 1'b0) begin errors++; $display("FAIL reset_verr got %b want 0", verify_err); end
    reset = 1'b0;
    ref_rr = 0;
    ref_rdata = '0;
  endtask

  task automatic test_directed_reads();
    logic [2:0]  addrs [3] = '{3'd0, 3'd4, 3'd7};
    logic [15:0] exp   [3] = '{16'hFFFF, 16'hABCD, 16'h0001};
    int lat, wp; logic [N-1:0] a, aa; logic [15:0] rd; logic ba;
    for (int i = 0; i < 3; i++) begin
      run_txn(0, 1'b0, addrs[i], 16'h0, lat, a, rd, wp, aa, ba);
      checks++;
      if (lat !== RD_LAT) begin errors++; $display("FAIL dir_read_lat a%0d got %0d want %0d", addrs[i], lat, RD_LAT); end
      checks++;
      if (rd !== exp[i]) begin errors++; $display("FAIL dir_read_data a%0d got %h want %h", addrs[i], rd, exp[i]); end
      checks++;
      if (a !== 2'b01) begin errors++; $display("FAIL dir_read_ack a%0d got %b want 01", addrs[i], a); end
      ref_rdata = exp[i];
      ref_rr = 1;
    end
  endtask

  task automatic test_write_read();
    int lat, wp; logic [N-1:0] a, aa; logic [15:0] rd; logic ba;
    run_txn(0, 1'b1, 3'd6, 16'hABCD, lat, a, rd, wp, aa, ba);
    checks++; if (lat !== WR_LAT) begin errors++; $display("FAIL wr_lat got %0d want %0d", lat, WR_LAT); end
    checks++; if (wp !== 1) begin errors++; $display("FAIL wr_pulses got %0d want 1", wp); end
    checks++; if (rd !== ref_rdata) begin errors++; $display("FAIL wr_rdata_hold got %h want %h", rd, ref_rdata); end
    ref_mem[6] = 16'hABCD;
    run_txn(0, 1'b0, 3'd6, 16'h0, lat, a, rd, wp, aa, ba);
    checks++; if (rd !== 16'hABCD) begin errors++; $display("FAIL rd_after_wr got %h want abcd", rd); end
    checks++; if (wp !== 0) begin errors++; $display("FAIL rd_pulses got %0d want 0", wp); end
    ref_rdata = 16'hABCD;
    ref_rr = 1;
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [15:0] rd1;
    @(negedge clk);
    req[1] = 1'b1; req_we[1] = 1'b0; req_addr[5:3] = 3'd1;
    lat = -1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (ack != '0) begin lat = c; break; end
    end
    checks++; if (lat !== RD_LAT) begin errors++; $display("FAIL b2b_lat1 got %0d want %0d", lat, RD_LAT); end
    checks++; if (ack !== 2'b10) begin errors++; $display("FAIL b2b_ack1 got %b want 10", ack); end
    rd1 = rdata;
    checks++; if (rd1 !== 16'h0000) begin errors++; $display("FAIL b2b_data1 got %h want 0000", rd1); end
    req_addr[5:3] = 3'd3;  // req stays high: a fresh request
    @(negedge clk);
    checks++;
    if ({ack, busy} !== '0) begin errors++; $display("FAIL b2b_gap ack=%b busy=%b want 0 0", ack, busy); end
    lat = -1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (ack != '0) begin lat = c; break; end
    end
    checks++; if (lat !== RD_LAT) begin errors++; $display("FAIL b2b_lat2 got %0d want %0d", lat, RD_LAT); end
    checks++; if (rdata !== 16'h0000) begin errors++; $display("FAIL b2b_data2 got %h want 0000", rdata); end
    req[1] = 1'b0;
    @(negedge clk);
    checks++; if (ack !== '0) begin errors++; $display("FAIL b2b_ack_width got %b want 0", ack); end
    ref_rdata = 16'h0000;
    ref_rr = 0;
  endtask

  task automatic test_random();
    int lat, wp, r; bit we; logic [2:0] ad; logic [15:0] wd, exp_rd;
    logic [N-1:0] a, aa; logic [15:0] rd; logic ba;
    for (int t = 0; t < 24; t++) begin
      r  = int'($urandom_range(0, N-1));
      we = 1'($urandom_range(0, 1));
      ad = 3'($urandom_range(0, 7));
      wd = 16'($urandom);
      run_txn(r, we, ad, wd, lat, a, rd, wp, aa, ba);
      exp_rd = we ? ref_rdata : ref_mem[ad];
      checks++;
      if (lat !== (we ? WR_LAT : RD_LAT)) begin
        errors++; $display("FAIL rand_lat t%0d got %0d want %0d", t, lat, we ? WR_LAT : RD_LAT);
      end
      checks++;
      if (a !== (N'(1) << r)) begin errors++; $display("FAIL rand_ack t%0d got %b req %0d", t, a, r); end
      checks++;
      if (rd !== exp_rd) begin errors++; $display("FAIL rand_rdata t%0d got %h want %h", t, rd, exp_rd); end
      checks++;
      if (wp !== int'(we)) begin errors++; $display("FAIL rand_wpulse t%0d got %0d want %0d", t, wp, we); end
      checks++;
      if ({aa, ba} !== '0) begin errors++; $display("FAIL rand_idle t%0d ack=%b busy=%b want 0", t, aa, ba); end
      if (we) ref_mem[ad] = wd;
      else    ref_rdata = ref_mem[ad];
      ref_rr = (r + 1) % N;
    end
    checks++; if (verify_err !== 1'b0) begin errors++; $display("FAIL rand_verr got %b want 0", verify_err); end
  endtask

  task automatic test_fairness();
    logic [2:0]  ja [N][4];
    logic [15:0] jd [N][4];
    int done_cnt [N];
    int exp_g, act_g, total, cand;
    apply_reset();
    for (int r = 0; r < N; r++) begin
      for (int k = 0; k < 4; k++) begin
        ja[r][k] = 3'($urandom_range(0, 7));
        jd[r][k] = 16'($urandom);
      end
      done_cnt[r] = 0;
    end
    @(negedge clk);
    for (int r = 0; r < N; r++) begin
      req[r] = 1'b1; req_we[r] = 1'b1;
      req_addr[3*r +: 3] = ja[r][0]; req_wdata[16*r +: 16] = jd[r][0];
    end
    total = 0;
    for (int c = 0; c < 100 && total < 4*N; c++) begin
      @(negedge clk);
      if (ack != '0) begin
        exp_g = -1;
        for (int k = 0; k < N; k++) begin
          cand = (ref_rr + k) % N;
          if (exp_g < 0 && done_cnt[cand] < 4) exp_g = cand;
        end
        checks++;
        if (ack !== (N'(1) << exp_g)) begin
          errors++; $display("FAIL fair_order n%0d got %b want req %0d", total, ack, exp_g);
        end
        act_g = 0;
        for (int k = N-1; k >= 0; k--) if (ack[k]) act_g = k;
        ref_mem[ja[act_g][done_cnt[act_g]]] = jd[act_g][done_cnt[act_g]];
        ref_rr = (exp_g + 1) % N;
        done_cnt[act_g]++;
        total++;
        if (done_cnt[act_g] < 4) begin
          req_addr[3*act_g +: 3] = ja[act_g][done_cnt[act_g]];
          req_wdata[16*act_g +: 16] = jd[act_g][done_cnt[act_g]];
        end else begin
          req[act_g] = 1'b0;
        end
      end
    end
    req = '0;
    checks++; if (total !== 4*N) begin errors++; $display("FAIL fair_total got %0d want %0d", total, 4*N); end
    @(negedge clk);
  endtask

  task automatic test_readback();
    int lat, wp; logic [N-1:0] a, aa; logic [15:0] rd; logic ba;
    for (int i = 0; i < 8; i++) begin
      run_txn(i % N, 1'b0, 3'(i), 16'h0, lat, a, rd, wp, aa, ba);
      checks++;
      if (rd !== ref_mem[i]) begin errors++; $display("FAIL readback a%0d got %h want %h", i, rd, ref_mem[i]); end
      ref_rdata = ref_mem[i];
      ref_rr = (i % N + 1) % N;
    end
  endtask

  task automatic test_reset_abort();
    int lat, wp, n_ack; logic [N-1:0] a, aa; logic [15:0] rd; logic ba;
    logic [N-1:0] acks [2]; logic [15:0] rds [2];
    run_txn(0, 1'b0, 3'd5, 16'h0, lat, a, rd, wp, aa, ba);  // leaves rr pointing at 1
    ref_rdata = ref_mem[5];
    @(negedge clk);
    req[1] = 1'b1; req_we[1] = 1'b0; req_addr[5:3] = 3'd2;
    repeat (2) @(negedge clk);  // ISSUE, then WAIT
    checks++; if (ack !== '0) begin errors++; $display("FAIL abort_early_ack got %b want 0", ack); end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({ack, rdata, busy, cfg_address, cfg_write, cfg_data_in, verify_err} !== '0) begin
      errors++;
      $display("FAIL abort_outputs ack=%b rdata=%h busy=%b addr=%h wr=%b din=%h verr=%b want all 0",
               ack, rdata, busy, cfg_address, cfg_write, cfg_data_in, verify_err);
    end
    reset = 1'b0;
    ref_rr = 0;
    ref_rdata = '0;
    req[0] = 1'b1; req_we[0] = 1'b0; req_addr[2:0] = 3'd4;
    n_ack = 0;
    acks[0] = 'x; acks[1] = 'x; rds[0] = 'x; rds[1] = 'x;
    for (int c = 0; c < 20 && n_ack < 2; c++) begin
      @(negedge clk);
      if (ack != '0) begin
        acks[n_ack] = ack; rds[n_ack] = rdata;
        if (ack[0]) req[0] = 1'b0;
        if (ack[1]) req[1] = 1'b0;
        n_ack++;
      end
    end
    req = '0;
    checks++; if (acks[0] !== 2'b01) begin errors++; $display("FAIL abort_first got %b want 01", acks[0]); end
    checks++;
    if (rds[0] !== ref_mem[4]) begin errors++; $display("FAIL abort_rd0 got %h want %h", rds[0], ref_mem[4]); end
    checks++; if (acks[1] !== 2'b10) begin errors++; $display("FAIL abort_second got %b want 10", acks[1]); end
    checks++;
    if (rds[1] !== ref_mem[2]) begin errors++; $display("FAIL abort_rd1 got %h want %h", rds[1], ref_mem[2]); end
    ref_rdata = ref_mem[2];
    ref_rr = 0;
    @(negedge clk);
  endtask

  task automatic test_verify();
    int lat, wp; logic [N-1:0] a, aa; logic [15:0] rd; logic ba;
`ifdef CFG_WRITE_VERIFY_EN
    force_bad = 1'b1;
    run_txn(0, 1'b1, 3'd3, 16'hFFFF, lat, a, rd, wp, aa, ba);
    force_bad = 1'b0;
    ref_mem[3] = 16'hFFFF;
    checks++; if (lat !== WR_LAT) begin errors++; $display("FAIL verify_lat got %0d want %0d", lat, WR_LAT); end
    checks++; if (verify_err !== 1'b1) begin errors++; $display("FAIL verify_set got %b want 1", verify_err); end
    run_txn(1, 1'b1, 3'd5, 16'h1111, lat, a, rd, wp, aa, ba);
    ref_mem[5] = 16'h1111;
    checks++; if (verify_err !== 1'b1) begin errors++; $display("FAIL verify_sticky got %b want 1", verify_err); end
`else
    run_txn(0, 1'b1, 3'd3, 16'hFFFF, lat, a, rd, wp, aa, ba);
    ref_mem[3] = 16'hFFFF;
    checks++; if (lat !== WR_LAT) begin errors++; $display("FAIL verify_off_lat got %0d want %0d", lat, WR_LAT); end
    checks++; if (verify_err !== 1'b0) begin errors++; $display("FAIL verify_off got %b want 0", verify_err); end
`endif
  endtask

  initial begin
    test_reset();
    test_directed_reads();
    test_write_read();
    test_back_to_back();
    test_random();
    test_fairness();
    test_readback();
    test_reset_abort();
    test_verify();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
